// File: rtl/mips_hazard_scoreboard_if.sv
// Bus between the ID/EX control path and the hazard scoreboard: ID-stage instruction
// attributes and branch resolution in, pipeline hold/bubble/flush and forwarding selects out.
interface mips_hazard_scoreboard_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 3
);
  localparam int unsigned SelW = $clog2(DEPTH);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_regwrite;
  logic              id_memread;
  logic [REG_AW-1:0] id_dest;
  logic              ex_branch_taken;

  logic              stall;
  logic              pc_hold;
  logic              ifid_hold;
  logic              bubble;
  logic              flush_ifid;
  logic [SelW-1:0]   fwd_a_sel;
  logic [SelW-1:0]   fwd_b_sel;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_regwrite, id_memread, id_dest,
    output ex_branch_taken,
    input  stall, pc_hold, ifid_hold, bubble, flush_ifid, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_regwrite, id_memread, id_dest,
    input  ex_branch_taken,
    output stall, pc_hold, ifid_hold, bubble, flush_ifid, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/mips_hazard_scoreboard.sv
// Scoreboard of in-flight register writers (entry 0 = EX .. DEPTH-1 = WB) producing stalls,
// bubbles, flushes and EX forwarding selects. Define HAZARD_FWD_EN to enable forwarding.
module mips_hazard_scoreboard #(
  parameter int unsigned REG_AW         = 5,
  parameter int unsigned DEPTH          = 3,
  parameter int unsigned LOAD_FWD_STAGE = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  mips_hazard_scoreboard_if.slave hz
);
  localparam int unsigned SelW = $clog2(DEPTH);

  if (DEPTH < 2 || LOAD_FWD_STAGE < 1 || LOAD_FWD_STAGE > DEPTH - 1) begin : g_bad_param
    $error("mips_hazard_scoreboard: DEPTH or LOAD_FWD_STAGE out of range");
  end

  typedef logic [REG_AW-1:0] reg_t;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
    reg_t dest;
    reg_t src_rs;
    reg_t src_rt;
    logic use_rs;
    logic use_rt;
  } entry_t;

  entry_t          entry_q [DEPTH];
  entry_t          entry_d [DEPTH];
  logic            stall_raw;
  logic            issue;
  logic [SelW-1:0] fwd_a;
  logic [SelW-1:0] fwd_b;

  // $0 is hard-wired, so a write to it never produces a dependency.
  function automatic logic match(input entry_t e, input reg_t r);
    return e.valid & e.regwrite & (e.dest == r) & (r != '0);
  endfunction

`ifdef HAZARD_FWD_EN
  // Only loads too young to forward block ID.
  localparam int StallLast = int'(LOAD_FWD_STAGE) - 2;
  localparam bit LoadOnly  = 1'b1;
`else
  // Without forwarding every producer short of the write-back stage blocks ID.
  localparam int StallLast = int'(DEPTH) - 2;
  localparam bit LoadOnly  = 1'b0;
`endif

  always_comb begin
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < int'(DEPTH); j++) begin
      if (j <= StallLast && (entry_q[j].memread || !LoadOnly)) begin
        if ((hz.id_use_rs && match(entry_q[j], hz.id_rs)) ||
            (hz.id_use_rt && match(entry_q[j], hz.id_rt))) begin
          hit = 1'b1;
        end
      end
    end
    stall_raw = hit & hz.id_valid;
  end

`ifdef HAZARD_FWD_EN
  logic blk_a;
  logic blk_b;

  // Youngest producer wins; a load that has not yet returned data cannot be a source.
  function automatic logic [SelW-1:0] pick(input reg_t src, input logic use_src,
                                           output logic blocked);
    logic [SelW-1:0] sel;
    logic            found;
    sel     = '0;
    blocked = 1'b0;
    found   = 1'b0;
    for (int k = 1; k < int'(DEPTH); k++) begin
      if (!found && use_src && match(entry_q[k], src)) begin
        found = 1'b1;
        if (entry_q[k].memread && k < int'(LOAD_FWD_STAGE)) begin
          blocked = 1'b1;
        end else begin
          sel = SelW'(k);
        end
      end
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = pick(entry_q[0].src_rs, entry_q[0].valid & entry_q[0].use_rs, blk_a);
    fwd_b = pick(entry_q[0].src_rt, entry_q[0].valid & entry_q[0].use_rt, blk_b);
  end

  // A blocked load forward means the load-use stall let a dependent instruction through.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(blk_a || blk_b));
    end
  end
`else
  assign fwd_a = '0;
  assign fwd_b = '0;
`endif

  assign issue = hz.id_valid & ~stall_raw & ~hz.ex_branch_taken;

  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      entry_d[k] = '0;
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      entry_d[k] = entry_q[k-1];
    end
    if (issue) begin
      entry_d[0].valid    = 1'b1;
      entry_d[0].regwrite = hz.id_regwrite;
      entry_d[0].memread  = hz.id_memread;
      entry_d[0].dest     = hz.id_dest;
      entry_d[0].src_rs   = hz.id_rs;
      entry_d[0].src_rt   = hz.id_rt;
      entry_d[0].use_rs   = hz.id_use_rs;
      entry_d[0].use_rt   = hz.id_use_rt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        entry_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        entry_q[k] <= entry_d[k];
      end
    end
  end

  // A taken branch wins over the stall: the PC must load the target, not hold.
  assign hz.stall      = rst_n & stall_raw;
  assign hz.pc_hold    = rst_n & stall_raw & ~hz.ex_branch_taken;
  assign hz.ifid_hold  = rst_n & stall_raw & ~hz.ex_branch_taken;
  assign hz.bubble     = rst_n & (stall_raw | hz.ex_branch_taken);
  assign hz.flush_ifid = hz.ex_branch_taken;
  assign hz.fwd_a_sel  = rst_n ? fwd_a : '0;
  assign hz.fwd_b_sel  = rst_n ? fwd_b : '0;

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Directed bench for mips_hazard_scoreboard; expectations follow whether HAZARD_FWD_EN is set.
module tb_mips_hazard_scoreboard;
  localparam int unsigned RegAw        = 5;
  localparam int unsigned Depth        = 3;
  localparam int unsigned LoadFwdStage = 2;
`ifdef HAZARD_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mips_hazard_scoreboard_if #(.REG_AW(RegAw), .DEPTH(Depth)) hz ();

  mips_hazard_scoreboard #(
    .REG_AW         (RegAw),
    .DEPTH          (Depth),
    .LOAD_FWD_STAGE (LoadFwdStage)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input int v, input int rs, input int rt, input int urs, input int urt,
                        input int rw, input int mr, input int dest);
    hz.id_valid    = (v != 0);
    hz.id_rs       = RegAw'(rs);
    hz.id_rt       = RegAw'(rt);
    hz.id_use_rs   = (urs != 0);
    hz.id_use_rt   = (urt != 0);
    hz.id_regwrite = (rw != 0);
    hz.id_memread  = (mr != 0);
    hz.id_dest     = RegAw'(dest);
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    nop();
    repeat (Depth) adv();
  endtask

  // Hold an instruction in ID until it issues, counting stall cycles (bounded).
  task automatic issue(input string tag, input int rs, input int rt, input int urs,
                       input int urt, input int rw, input int mr, input int dest,
                       input int exp_stalls);
    int n = 0;
    set_id(1, rs, rt, urs, urt, rw, mr, dest);
    #2;
    while (hz.stall && n < 8) begin
      check({tag, "_pc_hold"}, int'(hz.pc_hold), 1);
      check({tag, "_bubble"}, int'(hz.bubble), 1);
      n++;
      adv();
      #2;
    end
    check({tag, "_stalls"}, n, exp_stalls);
    adv();
    nop();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nop();
    hz.ex_branch_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_stall",     int'(hz.stall),      0);
    check("rst_pc_hold",   int'(hz.pc_hold),    0);
    check("rst_ifid_hold", int'(hz.ifid_hold),  0);
    check("rst_bubble",    int'(hz.bubble),     0);
    check("rst_fwd_a",     int'(hz.fwd_a_sel),  0);
    check("rst_fwd_b",     int'(hz.fwd_b_sel),  0);
    check("rst_flush",     int'(hz.flush_ifid), 0);
    hz.ex_branch_taken = 1'b1;
    #1;
    check("rst_flush_br",  int'(hz.flush_ifid), 1);
    check("rst_bubble_br", int'(hz.bubble),     0);
    hz.ex_branch_taken = 1'b0;
    adv();
    rst_n = 1'b1;

    // add $3,$1,$2 ; sub $4,$3,$5
    issue("t1_add", 1, 2, 1, 1, 1, 0, 3, 0);
    issue("t1_sub", 3, 5, 1, 1, 1, 0, 4, Fwd ? 0 : 2);
    #2;
    check("t1_fwd_a", int'(hz.fwd_a_sel), Fwd ? 1 : 0);
    check("t1_fwd_b", int'(hz.fwd_b_sel), 0);
    check("t1_flush", int'(hz.flush_ifid), 0);
    drain();

    // two producers of $3, consumer reads $3 on rs only
    issue("t2_p1", 1, 2, 1, 1, 1, 0, 3, 0);
    issue("t2_p2", 4, 5, 1, 1, 1, 0, 3, 0);
    issue("t2_c", 3, 3, 1, 0, 1, 0, 7, Fwd ? 0 : 2);
    #2;
    check("t2_fwd_a", int'(hz.fwd_a_sel), Fwd ? 1 : 0);
    check("t2_fwd_b", int'(hz.fwd_b_sel), 0);
    drain();
    issue("t2_p1b", 1, 2, 1, 1, 1, 0, 3, 0);
    adv();
    issue("t2_cb", 3, 9, 1, 1, 1, 0, 7, Fwd ? 0 : 1);
    #2;
    check("t2_fwd_a_old", int'(hz.fwd_a_sel), Fwd ? 2 : 0);
    check("t2_fwd_b_old", int'(hz.fwd_b_sel), 0);
    drain();

    // lw $2,0($1) ; add $6,$2,$7
    issue("t3_lw", 1, 2, 1, 0, 1, 1, 2, 0);
    issue("t3_add", 2, 7, 1, 1, 1, 0, 6, Fwd ? 1 : 2);
    #2;
    check("t3_fwd_a", int'(hz.fwd_a_sel), Fwd ? 2 : 0);
    check("t3_fwd_b", int'(hz.fwd_b_sel), 0);
    drain();

    // writes to $0 never match; then an rt-side dependency
    issue("t4_p0", 1, 2, 1, 1, 1, 0, 0, 0);
    issue("t4_c0", 0, 0, 1, 1, 1, 0, 8, 0);
    #2;
    check("t4_fwd_a", int'(hz.fwd_a_sel), 0);
    check("t4_fwd_b", int'(hz.fwd_b_sel), 0);
    drain();
    issue("t4_pb", 1, 2, 1, 1, 1, 0, 9, 0);
    issue("t4_cb", 4, 9, 1, 1, 1, 0, 10, Fwd ? 0 : 2);
    #2;
    check("t4_fwd_b_rt", int'(hz.fwd_b_sel), Fwd ? 1 : 0);
    check("t4_fwd_a_rt", int'(hz.fwd_a_sel), 0);
    drain();

    // load-use in ID while the EX branch resolves taken
    issue("t5_lw", 1, 2, 1, 0, 1, 1, 2, 0);
    set_id(1, 2, 7, 1, 1, 1, 0, 6);
    hz.ex_branch_taken = 1'b1;
    #2;
    check("t5_stall",     int'(hz.stall),      1);
    check("t5_pc_hold",   int'(hz.pc_hold),    0);
    check("t5_ifid_hold", int'(hz.ifid_hold),  0);
    check("t5_bubble",    int'(hz.bubble),     1);
    check("t5_flush",     int'(hz.flush_ifid), 1);
    adv();
    hz.ex_branch_taken = 1'b0;
    // killed add ($6) must be absent; the shifted lw ($2) must still be tracked
    issue("t5_or", 6, 2, 1, 1, 1, 0, 8, Fwd ? 0 : 1);
    #2;
    check("t5_fwd_a", int'(hz.fwd_a_sel), 0);
    check("t5_fwd_b", int'(hz.fwd_b_sel), Fwd ? 2 : 0);
    drain();

    // reset asserted in the middle of a load-use stall
    issue("t6_add", 3, 4, 1, 1, 1, 0, 1, 0);
    issue("t6_lw", 1, 5, 1, 0, 1, 1, 2, Fwd ? 0 : 2);
    set_id(1, 2, 7, 1, 1, 1, 0, 6);
    #2;
    check("t6_pre_stall", int'(hz.stall), 1);
    check("t6_pre_fwd_a", int'(hz.fwd_a_sel), Fwd ? 1 : 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_stall",   int'(hz.stall),     0);
    check("t6_rst_pc_hold", int'(hz.pc_hold),   0);
    check("t6_rst_bubble",  int'(hz.bubble),    0);
    check("t6_rst_fwd_a",   int'(hz.fwd_a_sel), 0);
    check("t6_rst_fwd_b",   int'(hz.fwd_b_sel), 0);
    adv();
    rst_n = 1'b1;
    issue("t6_post_dep", 2, 7, 1, 1, 1, 0, 6, 0);
    issue("t6_post_add", 1, 1, 1, 1, 1, 0, 1, 0);
    #2;
    check("t6_post_fwd_a", int'(hz.fwd_a_sel), 0);
    check("t6_post_fwd_b", int'(hz.fwd_b_sel), 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mips_hazard_scoreboard.md
Name: mips_hazard_scoreboard

Overview:
- Parametrised successor to the fixed hazard-detection and forwarding logic of the 5-stage MIPS pipeline.
- Keeps an internal scoreboard of in-flight register writers, one entry per post-ID stage (entry 0 = EX, entry DEPTH-1 = WB).
- From that scoreboard it produces forwarding selects, load-use stalls, bubble injection and branch flushes.
- Sits beside the ID/EX control path and replaces separate hazard-detection and forwarding units.

Parameters:
REG_AW, 5, register address width
DEPTH, 3, tracked post-ID stages (EX..WB), >=2
LOAD_FWD_STAGE, 2, first entry index whose load data is forwardable, 1..DEPTH-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_AW  ID source A
id_rt  in  REG_AW  ID source B
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_regwrite  in  1  ID instruction writes a register
id_memread  in  1  ID instruction is a load
id_dest  in  REG_AW  resolved destination (post-RegDst)
ex_branch_taken  in  1  branch in EX resolved taken
stall  out  1  load-use or no-forward stall
pc_hold  out  1  = stall & ~ex_branch_taken
ifid_hold  out  1  = stall & ~ex_branch_taken
bubble  out  1  zero ID/EX control this cycle
flush_ifid  out  1  = ex_branch_taken
fwd_a_sel  out  $clog2(DEPTH)  EX operand A source: 0 = register file, k = entry k
fwd_b_sel  out  $clog2(DEPTH)  EX operand B source, same encoding

Behaviour:
- Entry fields: valid, regwrite, memread, dest, src_rs, src_rt, use_rs, use_rt.
- Every clock the entries shift: entry k -> k+1, and entry DEPTH-1 retires.
- issue = id_valid & ~stall & ~ex_branch_taken.
  - If issue, entry 0 is loaded from the ID inputs.
  - Otherwise entry 0 is loaded invalid (bubble).
- bubble = stall | ex_branch_taken.
- Match(k, r) = entry k valid & regwrite & dest == r & r != 0.
- Forwarding:
  - fwd_a_sel = smallest k in 1..DEPTH-1 with Match(k, entry0.src_rs) & entry0.use_rs & entry0.valid; 0 if there is none. Youngest producer wins.
  - If the youngest match is a load with k < LOAD_FWD_STAGE, the select is 0. This cannot occur when the stall logic is correct; it is an assertion target.
  - fwd_b_sel is the same, using src_rt.
- Load-use stall: asserted when ID uses r (via id_use_rs or id_use_rt), and for some j <= LOAD_FWD_STAGE-2, entry j is a load with Match(j, r).
- Default stall length is 1 cycle.
- Outputs are combinational from the entries and current inputs. There is no added latency.
- Priority: ex_branch_taken overrides stall.
  - stall is still reported.
  - pc_hold and ifid_hold are 0, so the PC loads the branch target.
  - The ID instruction is killed.
  - The branch itself shifts to entry 1 normally.
- A register write to $0 never creates a match.
- Reset (asynchronous, any time including mid-stall):
  - All entries are invalid immediately.
  - Every output is 0 while rst_n is low, except flush_ifid, which tracks ex_branch_taken.
  - After reset release the scoreboard is empty, with no residual stall.
- The register file writes in the first half of the cycle, so entry DEPTH-1 never needs to block ID.

Optional Feature:
HAZARD_FWD_EN
- Defined: forwarding as above.
- Undefined:
  - fwd_a_sel and fwd_b_sel are tied to 0.
  - stall is asserted while any entry j <= DEPTH-2 gives Match(j, r) for a used ID source, whether or not it is a load.
  - For DEPTH=3 a dependent ALU pair stalls 2 cycles.

Test Plan:
1. add $3,$1,$2 then sub $4,$3,$5 back-to-back -> stall=0 throughout; fwd_a_sel=1 in the cycle sub is in EX.
2. Producers of $3 in entries 1 and 2, consumer of $3 in EX -> fwd_a_sel=1 (youngest wins); with the entry-1 producer removed -> fwd_a_sel=2.
3. lw $2,0($1) then add $6,$2,$7:
   - stall=1, pc_hold=1, bubble=1 for exactly one cycle;
   - in the next cycle add enters EX with fwd_a_sel=2.
4. Producer writes $0, consumer reads $0 -> fwd selects 0, stall=0.
5. Load-use condition in ID coincident with ex_branch_taken=1:
   - flush_ifid=1, pc_hold=0, bubble=1;
   - next cycle entry 0 is invalid and entry 1 holds the branch.
6. rst_n pulled low during a load-use stall -> stall, pc_hold and fwd selects go 0 immediately; after release, add $1,$1,$1 issues with no stall.
   - Repeat test 1 with HAZARD_FWD_EN undefined -> stall=1 for 2 cycles, then fwd selects=0.
